// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch constants and key FSM state encoding
package stopwatch_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES     = 25_000_000;
  localparam int DEF_REPEAT_CYCLES   = 5_000_000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// rtl/key_debounce_chan.sv - synchronizer, debounce FSM and counters for one key
// Auto-repeat while held is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_chan
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             pressed_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             rep_q, rep_d;
  assign rpt_inc = (rpt_q == '1) ? rpt_q : rpt_q + 1'b1;
`endif

  assign pressed_s = ~sync2_q;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    // Repeat timer only survives while HELD; any other state clears it.
    rpt_d     = '0;
    rep_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rpt_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
          press_d = 1'b1;
          rpt_d   = '0;
          rep_d   = 1'b1;
        end else begin
          rpt_d = rpt_inc;
          rep_d = rep_q;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q     <= '0;
      rep_q     <= 1'b0;
`endif
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
      rep_q     <= rep_d;
`endif
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced level and press/release pulses for the KEY buttons
// Optional auto-repeat per channel: KEY_AUTOREPEAT_EN.
module key_conditioner
  import stopwatch_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : gen_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk           (CLOCK_50),
      .rst_n         (RESET_N),
      .key_n         (KEY[i]),
      .level         (key_level[i]),
      .press_pulse   (key_press[i]),
      .release_pulse (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed scoreboard bench for key_conditioner
module tb_key_conditioner;

  localparam int DEB = 4;
  localparam int HOLD = 10;
  localparam int REP = 3;
  localparam int LAT = DEB + 3;  // drive after edge k -> pulse seen after edge k+7

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic [1:0] key_level, key_press, key_release;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  // entry: {cycle[15:0], channel, kind[1:0]}; kind 01 = press, 10 = release
  logic [18:0] sb[$];
  localparam logic [18:0] NONE = '1;

  key_conditioner #(
    .NUM_KEYS        (2),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .KEY         (key),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input int ch, input logic [1:0] kind);
    sb.push_back({16'(c), 1'(ch), kind});
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (key_press[ch] || key_release[ch]) begin
        logic [18:0] obs_k, exp_k;
        obs_k = {16'(cyc), 1'(ch), key_release[ch], key_press[ch]};
        exp_k = (sb.size() > 0) ? sb.pop_front() : NONE;
        n_assert++;
        assert (obs_k === exp_k) else begin
          n_fail++;
          $error("FAIL pulse: observed %0h expected %0h (cycle %0d)", obs_k, exp_k, cyc);
        end
      end
    end
  end

  initial begin
    int k;
    int r;
    int p;

    // 1: reset state and quiet idle
    key   = 2'b11;
    rst_n = 1'b0;
    tick(3);
    chk("reset_outputs", {26'd0, key_level, key_press, key_release}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(10);
      chk("idle_level", {30'd0, key_level}, 32'd0);
    end
    chk("idle_sb_empty", sb.size(), 0);

    // 2: clean press on key 0
    k = cyc;
    key[0] = 1'b0;
    push_ev(k + LAT, 0, 2'b01);
    tick(LAT - 1);
    chk("press_level_before", {30'd0, key_level}, 32'd0);
    tick(1);
    chk("press_level_after", {30'd0, key_level}, 32'd1);
    tick(5);
    chk("press_level_hold", {30'd0, key_level}, 32'd1);
    chk("press_sb_empty", sb.size(), 0);

    // clean release
    k = cyc;
    key[0] = 1'b1;
    push_ev(k + LAT, 0, 2'b10);
    tick(LAT - 1);
    chk("release_level_before", {30'd0, key_level}, 32'd1);
    tick(3);
    chk("release_level_after", {30'd0, key_level}, 32'd0);
    chk("release_sb_empty", sb.size(), 0);

    // 3: bouncing input is rejected
    for (int i = 0; i < 5; i++) begin
      key[0] = 1'b0;
      tick(2);
      key[0] = 1'b1;
      tick(2);
      chk("bounce_level", {30'd0, key_level}, 32'd0);
    end
    tick(20);
    chk("bounce_level_end", {30'd0, key_level}, 32'd0);
    chk("bounce_sb_empty", sb.size(), 0);

    // 4: press, then release with a glitch inside the release debounce window
    k = cyc;
    key[0] = 1'b0;
    push_ev(k + LAT, 0, 2'b01);
    tick(10);
    chk("glitch_pre_level", {30'd0, key_level}, 32'd1);
    key[0] = 1'b1;
    tick(3);
    key[0] = 1'b0;
    tick(2);
    key[0] = 1'b1;
    k = cyc;
    push_ev(k + LAT, 0, 2'b10);
    tick(LAT - 1);
    chk("glitch_level_held", {30'd0, key_level}, 32'd1);
    tick(1);
    chk("glitch_level_released", {30'd0, key_level}, 32'd0);
    tick(3);
    chk("glitch_sb_empty", sb.size(), 0);

    // 5: both keys pressed, reset mid-debounce, keys still held afterwards
    key = 2'b00;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk("midreset_outputs", {26'd0, key_level, key_press, key_release}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    r = cyc;
    push_ev(r + LAT, 0, 2'b01);
    push_ev(r + LAT, 1, 2'b01);
    tick(LAT - 1);
    chk("both_level_before", {30'd0, key_level}, 32'd0);
    tick(1);
    chk("both_level_after", {30'd0, key_level}, 32'd3);
    k = cyc;
    key = 2'b11;
    push_ev(k + LAT, 0, 2'b10);
    push_ev(k + LAT, 1, 2'b10);
    tick(LAT + 3);
    chk("both_level_released", {30'd0, key_level}, 32'd0);
    chk("both_sb_empty", sb.size(), 0);

    // 6: long hold; repeats only with auto-repeat built in
    k = cyc;
    key[0] = 1'b0;
    p = k + LAT;
    push_ev(p, 0, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
    for (int t = HOLD; t <= 32; t += REP) push_ev(p + t, 0, 2'b01);
`endif
    tick(LAT + 30);
    chk("hold_level", {30'd0, key_level}, 32'd1);
    k = cyc;
    key[0] = 1'b1;
    push_ev(k + LAT, 0, 2'b10);
    tick(LAT + 5);
    chk("hold_level_released", {30'd0, key_level}, 32'd0);
    chk("final_outputs", {26'd0, key_level, key_press, key_release}, 32'd0);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
